// File: rtl/alu_mul_seq_if.sv
// Operand/result bundle between the MIPS datapath and the iterative multiplier.
// Signal names keep the multiplier's own port naming so the datapath side reads naturally.
interface alu_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic [1:0]       dbg_state_o;

    // Handshake: the requester raises start_i with operands and holds it until it sees busy_o;
    // start_i is accepted only while idle, busy_o covers the loop, done_o pulses one cycle with hi/lo valid.
    modport master (
        output start_i, signed_i, src1_i, src2_i,
        input  busy_o, done_o, hi_o, lo_o, dbg_state_o
    );

    modport slave (
        input  start_i, signed_i, src1_i, src2_i,
        output busy_o, done_o, hi_o, lo_o, dbg_state_o
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier for MIPS mult/multu; writes HI/LO after a busy/done sequence.
// Optional macro ALU_MUL_EARLY_EXIT_EN ends the loop once the remaining multiplier bits are zero.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    alu_mul_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     mag1, mag2, mplier_shr;
    logic [2*WIDTH-1:0]   acc_sum, product;
    logic [CW-1:0]        cnt_inc;
    logic                 run_exit;

    always_comb begin
        // Signed operands run through the unsigned loop as magnitudes; the sign is reapplied at the end.
        mag1       = (bus.signed_i && bus.src1_i[WIDTH-1]) ? ('0 - bus.src1_i) : bus.src1_i;
        mag2       = (bus.signed_i && bus.src2_i[WIDTH-1]) ? ('0 - bus.src2_i) : bus.src2_i;
        acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_shr = mplier_q >> 1;
        cnt_inc    = cnt_q + CW'(1);
        product    = neg_q ? ('0 - acc_sum) : acc_sum;
`ifdef ALU_MUL_EARLY_EXIT_EN
        run_exit   = (cnt_inc == CW'(WIDTH)) || (mplier_shr == '0);
`else
        run_exit   = (cnt_inc == CW'(WIDTH));
`endif

        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = done_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag1};
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = bus.signed_i & (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1]);
                    state_d  = ST_RUN;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_shr;
                cnt_d    = cnt_inc;
                if (run_exit) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    lo_d    = product[WIDTH-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.dbg_state_o = state_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: arithmetic reference model checked every cycle, plus
// a scoreboard of hand-computed products and hand-computed done latencies.
module tb_alu_mul_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_mul_seq_if #(.WIDTH(W)) bus ();
  alu_mul_seq #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sgn) return sa * sb;
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic int ref_latency(input logic sgn, input logic [31:0] b);
    logic [31:0] m;
    int k;
    m = (sgn && b[31]) ? (32'd0 - b) : b;
    k = 1;
    for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
`ifdef ALU_MUL_EARLY_EXIT_EN
    return k;
`else
    return (k > 0) ? W : W;
`endif
  endfunction

  bit          m_valid = 0;
  bit          m_busy, m_done;
  logic [W-1:0] m_hi, m_lo;
  logic [2*W-1:0] m_prod;
  int          m_left;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_valid) begin
      if (m_done) m_done = 0;
      else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; {m_hi, m_lo} = m_prod;
        end
      end else if (bus.start_i) begin
        m_prod = ref_product(bus.signed_i, bus.src1_i, bus.src2_i);
        m_left = ref_latency(bus.signed_i, bus.src2_i);
        m_busy = 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", {63'b0, bus.busy_o}, {63'b0, m_busy});
      check("done", {63'b0, bus.done_o}, {63'b0, m_done});
      check("hi", {32'b0, bus.hi_o}, {32'b0, m_hi});
      check("lo", {32'b0, bus.lo_o}, {32'b0, m_lo});
      if (bus.done_o) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_unexpected_done: got %h%h expected none", bus.hi_o, bus.lo_o);
        end else begin
          check("sb_product", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_mul(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_p, input int exp_done);
    int cyc;
    bit got;
    exp_q.push_back(exp_p);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = sgn; bus.src1_i = a; bus.src2_i = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 1;
    got = 0;
    while (!got && cyc <= 200) begin
      @(negedge clk);
      if (bus.done_o) got = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p1, p2;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.src1_i = '0; bus.src2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy_o}, 64'd0);
    check("rst_done", {63'b0, bus.done_o}, 64'd0);
    check("rst_hi", {32'b0, bus.hi_o}, 64'd0);
    check("rst_lo", {32'b0, bus.lo_o}, 64'd0);
    rst_n = 1'b1;

`ifdef ALU_MUL_EARLY_EXIT_EN
    run_mul("t1_3x5", 1'b0, 32'd3, 32'd5, 64'd15, 4);
    run_mul("t2_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);
    run_mul("t3_neg3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 4);
    run_mul("t3_minxm1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 2);
    run_mul("t3_maxxmin", 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 33);
    run_mul("t6_9x3", 1'b0, 32'd9, 32'd3, 64'd27, 3);
    run_mul("t6_9x0", 1'b0, 32'd9, 32'd0, 64'd0, 2);
`else
    run_mul("t1_3x5", 1'b0, 32'd3, 32'd5, 64'd15, 33);
    run_mul("t2_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);
    run_mul("t3_neg3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 33);
    run_mul("t3_minxm1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    run_mul("t3_maxxmin", 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 33);
    run_mul("t6_9x3", 1'b0, 32'd9, 32'd3, 64'd27, 33);
    run_mul("t6_9x0", 1'b0, 32'd9, 32'd0, 64'd0, 33);
`endif

    // Test 4: extra start pulses while busy and in the done cycle are ignored.
`ifdef ALU_MUL_EARLY_EXIT_EN
    p1 = 2; p2 = 4;
`else
    p1 = 5; p2 = 33;
`endif
    exp_q.push_back(64'd49);
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.src1_i = 32'd7; bus.src2_i = 32'd7;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == p1 || c == p2) begin
        bus.start_i = 1'b1; bus.src1_i = 32'd2; bus.src2_i = 32'd2;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    check("t4_hold_lo", {32'b0, bus.lo_o}, 64'd49);
    check("t4_hold_hi", {32'b0, bus.hi_o}, 64'd0);
    check("t4_single_result", 64'(exp_q.size()), 64'd0);

    // Test 5: reset in cycle 10 of RUN aborts without writing a result.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0; bus.src1_i = 32'h00012345; bus.src2_i = 32'h80000001;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_abort_busy", {63'b0, bus.busy_o}, 64'd0);
    check("t5_abort_done", {63'b0, bus.done_o}, 64'd0);
    check("t5_abort_hi", {32'b0, bus.hi_o}, 64'd0);
    check("t5_abort_lo", {32'b0, bus.lo_o}, 64'd0);
`ifdef ALU_MUL_EARLY_EXIT_EN
    run_mul("t5_2x3", 1'b0, 32'd2, 32'd3, 64'd6, 3);
`else
    run_mul("t5_2x3", 1'b0, 32'd2, 32'd3, 64'd6, 33);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
